// File: rtl/simd_mac_pipe.sv
// simd_mac_pipe: packed-SIMD lane multiplier / dot-product accumulator with
// configurable latency, valid/ready back-pressure, flush and saturating DOT.
module simd_mac_pipe #(
  parameter int XLEN          = 32,
  parameter int LANE_W        = 8,
  parameter int PIPE_STAGES   = 2,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [1:0]               op_i,
  input  logic                     signed_a_i,
  input  logic                     signed_b_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [XLEN-1:0]          operand_c_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic                     busy_o
);
  localparam int NL  = XLEN / LANE_W;
  localparam int PW  = 2 * LANE_W + 2;
  localparam int SW  = XLEN + 2 * LANE_W + 2;
  localparam int PRE = PIPE_STAGES - 1;
  localparam logic signed [SW-1:0] SMAX = SW'({1'b0, {(XLEN-1){1'b1}}});
  localparam logic signed [SW-1:0] SMIN = ~SMAX;
  typedef struct packed {
    logic [1:0]               op;
    logic                     sa;
    logic                     sb;
    logic [TRANS_ID_BITS-1:0] tid;
    logic [XLEN-1:0]          a;
    logic [XLEN-1:0]          b;
    logic [XLEN-1:0]          c;
  } op_t;
  op_t  in_op, src;
  logic advance, accept, src_v, pre_busy;
  logic valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [TRANS_ID_BITS-1:0] tid_q, tid_d;
  assign in_op   = '{op: op_i, sa: signed_a_i, sb: signed_b_i, tid: trans_id_i,
                     a: operand_a_i, b: operand_b_i, c: operand_c_i};
  assign advance = !(valid_q && !ready_i);
  assign accept  = valid_i && advance;
  assign ready_o = advance;
  // Operands ride unchanged through the leading stages; arithmetic happens
  // in front of the output register.
  generate
    if (PRE > 0) begin : g_pre
      op_t pre_q [PRE];
      op_t pre_d [PRE];
      logic [PRE-1:0] pv_q, pv_d;
      always_comb begin
        pv_d[0]  = flush_i ? 1'b0 : advance ? accept : pv_q[0];
        pre_d[0] = advance ? in_op : pre_q[0];
        for (int s = 1; s < PRE; s++) begin
          pv_d[s]  = flush_i ? 1'b0 : advance ? pv_q[s-1] : pv_q[s];
          pre_d[s] = advance ? pre_q[s-1] : pre_q[s];
        end
      end
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pv_q <= '0;
        else         pv_q <= pv_d;
      end
      always_ff @(posedge clk_i) pre_q <= pre_d;
      assign src      = pre_q[PRE-1];
      assign src_v    = pv_q[PRE-1];
      assign pre_busy = |pv_q;
    end else begin : g_nopre
      assign src      = in_op;
      assign src_v    = accept;
      assign pre_busy = 1'b0;
    end
  endgenerate
  logic signed [LANE_W:0]  ea, eb;
  logic signed [PW-1:0]    p;
  logic signed [SW-1:0]    sum;
  logic [XLEN-1:0]         lo, hi, sat, res;
  always_comb begin
    ea  = '0;
    eb  = '0;
    p   = '0;
    lo  = '0;
    hi  = '0;
    sum = SW'($signed(src.c));
    for (int i = 0; i < NL; i++) begin
      ea = {src.sa & src.a[i*LANE_W+LANE_W-1], src.a[i*LANE_W +: LANE_W]};
      eb = {src.sb & src.b[i*LANE_W+LANE_W-1], src.b[i*LANE_W +: LANE_W]};
      p  = PW'(ea) * PW'(eb);
      lo[i*LANE_W +: LANE_W] = p[LANE_W-1:0];
      hi[i*LANE_W +: LANE_W] = p[2*LANE_W-1:LANE_W];
      sum = sum + SW'(p);
    end
    sat = sum > SMAX ? {1'b0, {(XLEN-1){1'b1}}} :
          sum < SMIN ? {1'b1, {(XLEN-1){1'b0}}} : sum[XLEN-1:0];
    res = src.op == 2'd0 ? lo :
          src.op == 2'd1 ? hi :
          src.op == 2'd2 ? sum[XLEN-1:0] : sat;
  end
  always_comb begin
    valid_d  = flush_i ? 1'b0 : advance ? src_v : valid_q;
    result_d = (advance && src_v) ? res : result_q;
    tid_d    = (advance && src_v) ? src.tid : tid_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      tid_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      tid_q    <= tid_d;
    end
  end
  assign valid_o    = valid_q;
  assign result_o   = result_q;
  assign trans_id_o = tid_q;
  assign busy_o     = valid_q | pre_busy;
endmodule

// File: tb/tb_simd_mac_pipe.sv
// tb_simd_mac_pipe: scoreboard bench for simd_mac_pipe; a driver pushes expected
// results on accept and an independent monitor pops them on each handshake.
module tb_simd_mac_pipe;
  localparam int XLEN = 32;
  localparam int LW   = 8;
  localparam int TB   = 3;
  localparam int NL   = XLEN / LW;
  localparam longint MAXS = (longint'(1) <<< (XLEN - 1)) - 1;
  localparam longint MINS = -MAXS - 1;
  logic clk = 0, rst_n = 0, flush = 0, valid_i = 0, ready_i = 1, sa = 0, sb = 0;
  logic ready_o, valid_o, busy;
  logic [1:0] op = 0;
  logic [TB-1:0] tid_i = 0, tid_o;
  logic [XLEN-1:0] a = 0, b = 0, c = 0, res;
  logic dir_en = 0;
  logic [XLEN-1:0] dir_exp = 0;
  int n_chk = 0, n_fail = 0;
  logic [TB+XLEN-1:0] sbq[$];
  logic stalled = 0;
  logic [TB+XLEN-1:0] held = 0;

  simd_mac_pipe #(.XLEN(XLEN), .LANE_W(LW), .PIPE_STAGES(2), .TRANS_ID_BITS(TB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op), .signed_a_i(sa), .signed_b_i(sb), .trans_id_i(tid_i),
    .operand_a_i(a), .operand_b_i(b), .operand_c_i(c), .valid_o(valid_o),
    .ready_i(ready_i), .result_o(res), .trans_id_o(tid_o), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] model(input logic [1:0] o, input logic s_a, input logic s_b,
                                            input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                                            input logic [XLEN-1:0] z);
    longint s, p, xa, yb;
    logic [LW-1:0] la, lb;
    logic [XLEN-1:0] r;
    r = '0;
    s = longint'($signed(z));
    for (int i = 0; i < NL; i++) begin
      la = x[i*LW +: LW];
      lb = y[i*LW +: LW];
      xa = s_a ? longint'($signed(la)) : longint'(la);
      yb = s_b ? longint'($signed(lb)) : longint'(lb);
      p  = xa * yb;
      s  = s + p;
      r[i*LW +: LW] = (o == 2'd0) ? LW'(p) : LW'(p >>> LW);
    end
    if (o == 2'd2) r = XLEN'(s);
    else if (o == 2'd3) r = (s > MAXS) ? XLEN'(MAXS) : (s < MINS) ? XLEN'(MINS) : XLEN'(s);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: record the expected response of every accepted operation.
  always @(negedge clk) begin
    if (!rst_n || flush) sbq.delete();
    else if (valid_i && ready_o)
      sbq.push_back({tid_i, dir_en ? dir_exp : model(op, sa, sb, a, b, c)});
  end

  // Monitor: compare each consumed result and check stalled outputs stay put.
  always @(negedge clk) begin
    if (rst_n && stalled) chk("stall_hold", {valid_o, tid_o, res}, {1'b1, held});
    if (rst_n && valid_o && ready_i && !flush) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got id %0d data 0x%0h with nothing expected", tid_o, res);
      end else chk("result", {tid_o, res}, sbq.pop_front());
    end
    stalled = rst_n && valid_o && !ready_i && !flush;
    held = {tid_o, res};
  end

  function automatic logic [XLEN-1:0] pick();
    int r;
    r = $urandom_range(0, 4);
    return r == 1 ? 32'h7F7F7F7F : r == 2 ? 32'h80808080 : r == 3 ? 32'hFFFFFFFF : $urandom;
  endfunction

  task automatic rand_op();
    op = 2'($urandom_range(0, 3));
    sa = 1'($urandom);
    sb = 1'($urandom);
    a = pick();
    b = pick();
    c = pick();
  endtask

  task automatic issue(input logic [1:0] o, input logic s_a, input logic s_b, input logic [TB-1:0] id,
                       input logic [XLEN-1:0] x, input logic [XLEN-1:0] y, input logic [XLEN-1:0] z,
                       input logic [XLEN-1:0] ex);
    logic acc;
    acc = 0;
    op = o; sa = s_a; sb = s_b; tid_i = id; a = x; b = y; c = z;
    dir_en = 1; dir_exp = ex; valid_i = 1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = ready_o && !flush;
      @(posedge clk); #1;
    end
    chk("issue_accepted", acc, 1);
    valid_i = 0;
    dir_en = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && (sbq.size() != 0 || valid_o); k++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", {sbq.size(), 31'b0, valid_o}, 0);
  endtask

  initial begin
    logic [XLEN-1:0] r0;
    int k;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_result_o", res, 0);
    chk("rst_trans_id_o", tid_o, 0);
    chk("rst_busy_o", busy, 0);
    chk("rst_ready_o", ready_o, 1);
    @(posedge clk); #1;
    rst_n = 1;
    // Reference vectors with fixed expected results.
    issue(2'd0, 1, 1, 3'd1, 32'h807FFF02, 32'h807FFF03, 32'd0, 32'h00010106);
    issue(2'd1, 1, 1, 3'd2, 32'h807FFF02, 32'h807FFF03, 32'd0, 32'h403F0000);
    issue(2'd1, 0, 0, 3'd3, 32'h807FFF02, 32'h807FFF03, 32'd0, 32'h403FFE00);
    issue(2'd2, 1, 0, 3'd4, 32'hFFFFFFFF, 32'h01020304, 32'd10, 32'h00000000);
    issue(2'd2, 1, 1, 3'd5, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7FFFFFF0, 32'h8000FBF4);
    issue(2'd3, 1, 1, 3'd6, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7FFFFFF0, 32'h7FFFFFFF);
    drain();
    // Back-pressure: three ops in cycles 0-2, consumer stalls cycles 2-4.
    rand_op(); tid_i = 3'd1; valid_i = 1;
    @(negedge clk); chk("bp_c0_valid_o", valid_o, 0);
    @(posedge clk); #1;
    rand_op(); tid_i = 3'd2;
    @(negedge clk); chk("bp_c1_valid_o", valid_o, 0);
    @(posedge clk); #1;
    rand_op(); tid_i = 3'd3; ready_i = 0;
    @(negedge clk);
    chk("bp_c2_out", {valid_o, tid_o, ready_o}, {1'b1, 3'd1, 1'b0});
    r0 = res;
    for (int cy = 3; cy <= 4; cy++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_frozen", {valid_o, tid_o, ready_o, res}, {1'b1, 3'd1, 1'b0, r0});
    end
    @(posedge clk); #1;
    ready_i = 1;
    @(negedge clk); chk("bp_release_ready", ready_o, 1);
    @(posedge clk); #1;
    valid_i = 0;
    @(negedge clk); chk("bp_c6_id", {valid_o, tid_o}, {1'b1, 3'd2});
    @(posedge clk); #1;
    @(negedge clk); chk("bp_c7_id", {valid_o, tid_o}, {1'b1, 3'd3});
    drain();
    // Flush kills ID 1; ID 2 issued afterwards arrives two cycles later.
    rand_op(); tid_i = 3'd1; valid_i = 1;
    @(posedge clk); #1;
    valid_i = 0; flush = 1;
    @(negedge clk); chk("fl_c1", {busy, valid_o}, {1'b1, 1'b0});
    @(posedge clk); #1;
    flush = 0; rand_op(); tid_i = 3'd2; valid_i = 1;
    @(negedge clk); chk("fl_c2", {busy, valid_o}, {1'b0, 1'b0});
    @(posedge clk); #1;
    valid_i = 0;
    @(negedge clk); chk("fl_c3_valid_o", valid_o, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("fl_c4", {valid_o, tid_o}, {1'b1, 3'd2});
    drain();
    // Asynchronous reset while a result is being held.
    issue(2'd0, 0, 0, 3'd5, 32'h01010101, 32'h02020202, 32'd0, 32'h02020202);
    ready_i = 0;
    k = 0;
    while (!valid_o && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("rr_busy_before", {valid_o, busy, res}, {1'b1, 1'b1, 32'h02020202});
    #1 rst_n = 0;
    #1 chk("rr_cleared", {valid_o, busy, res}, {1'b0, 1'b0, 32'h0});
    repeat (2) @(posedge clk);
    #1 rst_n = 1; ready_i = 1;
    // Randomised traffic with random stalls and occasional flushes.
    for (int cy = 0; cy < 600; cy++) begin
      rand_op();
      tid_i = 3'($urandom);
      valid_i = $urandom_range(0, 3) != 0;
      ready_i = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 40) == 0;
      @(posedge clk); #1;
    end
    valid_i = 0; flush = 0; ready_i = 1;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule
